// File: rtl/tile_n_solver_pkg.sv
// Shared types for the tile-count solver: layer kinds, error flag layout and FSM states.
package tile_n_solver_pkg;

  typedef enum logic [1:0] {
    LT_PW  = 2'd0,
    LT_DW  = 2'd1,
    LT_STD = 2'd2,
    LT_LIN = 2'd3
  } layer_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DIV   = 2'd2,
    ST_ALIGN = 2'd3
  } state_e;

  localparam int unsigned ERR_NOFIT = 0;
  localparam int unsigned ERR_DIV0  = 1;
  localparam logic [1:0]  ERR_NOFIT_M = 2'b01;
  localparam logic [1:0]  ERR_DIV0_M  = 2'b10;

  // Headroom above N_W so footprint products never wrap.
  localparam int unsigned EXT_W = 16;

endpackage

// File: rtl/tile_n_solver_if.sv
// Start/done handshake and layer-geometry bundle between the controller and the tile-count solver.
interface tile_n_solver_if #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned N_W   = 32
);
  logic             start;
  logic             ready;
  logic [1:0]       layer_type;
  logic [1:0]       kH;
  logic [1:0]       kW;
  logic [DIM_W-1:0] tile_D;
  logic [DIM_W-1:0] tile_K;
  logic [DIM_W-1:0] tile_D_f;
  logic [DIM_W-1:0] tile_K_f;
  logic [DIM_W-1:0] M1;
  logic [DIM_W-1:0] M2;
  logic [DIM_W-1:0] M3;
  logic             done;
  logic [N_W-1:0]   tile_n;
  logic [1:0]       err;

  modport slave (
    input  start, layer_type, kH, kW, tile_D, tile_K, tile_D_f, tile_K_f, M1, M2, M3,
    output ready, done, tile_n, err
  );

  modport master (
    output start, layer_type, kH, kW, tile_D, tile_K, tile_D_f, tile_K_f, M1, M2, M3,
    input  ready, done, tile_n, err
  );
endinterface

// File: rtl/tile_n_solver_seq_udiv.sv
// Restoring unsigned divider producing a W-bit quotient, one bit per cycle, from a (W+XW)-bit dividend.
// A quotient that would not fit in W bits saturates to all ones.
module seq_udiv #(
  parameter int unsigned W  = 32,
  parameter int unsigned XW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W+XW-1:0] dividend,
  input  logic [W+XW-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    quotient
);

  localparam int unsigned DVD_W = W + XW;
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [DVD_W-1:0] rem_r;
  logic [DVD_W-1:0] dsr_r;
  logic [W-1:0]     quo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             ovf_r;
  logic [DVD_W:0]   trial_s;
  logic             fit_s;

  // Trial subtraction for the current quotient bit.
  always_comb begin
    trial_s = {rem_r, quo_r[W-1]};
    fit_s   = (trial_s >= {1'b0, dsr_r});
  end

  // Iteration state: the low dividend bits shift out of quo_r as quotient bits shift in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r  <= '0;
      dsr_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (start) begin
      // Upper dividend bits start as the partial remainder; if they already reach the divisor the quotient overflows W bits.
      rem_r  <= DVD_W'(dividend[DVD_W-1:W]);
      quo_r  <= dividend[W-1:0];
      dsr_r  <= divisor;
      ovf_r  <= (DVD_W'(dividend[DVD_W-1:W]) >= divisor);
      cnt_r  <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= fit_s ? DVD_W'(trial_s - {1'b0, dsr_r}) : trial_s[DVD_W-1:0];
      quo_r  <= {quo_r[W-2:0], fit_s};
      cnt_r  <= cnt_r + CNT_W'(1);
      busy_r <= (cnt_r != CNT_W'(W - 1));
    end else begin
      busy_r <= 1'b0;
    end
  end

  // done flags the cycle whose edge computes the final bit; quotient is valid from the next cycle on.
  assign busy     = busy_r;
  assign done     = busy_r && (cnt_r == CNT_W'(W - 1));
  assign quotient = ovf_r ? {W{1'b1}} : quo_r;

endmodule

// File: rtl/tile_n_solver.sv
// Computes the largest tile_n whose activations, weights, bias and psums fit in the GLB,
// with start/done handshake, early-exit error flags, clamping and pointwise alignment.
module tile_n_solver
  import tile_n_solver_pkg::*;
#(
  parameter longint unsigned GLB_BYTES     = 64'd65536,
  parameter int unsigned     BYTES_I       = 1,
  parameter int unsigned     BYTES_W       = 1,
  parameter int unsigned     BYTES_P       = 1,
  parameter int unsigned     DIM_W         = 8,
  parameter int unsigned     N_W           = 32,
  parameter int unsigned     PW_ALIGN_LOG2 = 2,
  parameter logic [N_W-1:0]  TILE_N_MAX    = {N_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  tile_n_solver_if.slave  bus
);

  localparam int unsigned EW = N_W + EXT_W;
  localparam logic [N_W-1:0] ALIGN_MASK = ~((N_W'(1) << PW_ALIGN_LOG2) - N_W'(1));

  state_e           state_r;
  logic             ready_r;
  logic             done_r;
  logic [N_W-1:0]   tile_n_r;
  logic [1:0]       err_r;
  layer_type_e      lt_r;
  logic [1:0]       kh_r, kw_r;
  logic [DIM_W-1:0] td_r, tk_r, tdf_r, tkf_r, m1_r, m2_r, m3_r;
  logic             early_r;
  logic [N_W-1:0]   res_r;
  logic [1:0]       err_pend_r;

  logic [EW-1:0]    f_s, b_s, r_s, d_s, num_s;
  logic [EW:0]      avail_s, cost_s;
  logic             nofit_s;
  logic             div_start_s, div_busy_s, div_done_s;
  logic [N_W-1:0]   div_quo_s, q_s, aligned_s;
  logic             align_nofit_s;

  // Footprint arithmetic on the latched geometry; NUM<=0 is detected without signed math.
  always_comb begin
    f_s     = EW'(kh_r) * EW'(kw_r) * EW'(tdf_r) * EW'(tkf_r) * EW'(BYTES_W);
    b_s     = EW'(tk_r) * EW'(BYTES_P);
    r_s     = EW'(m2_r) * EW'(m3_r) * EW'(tk_r) * EW'(BYTES_P);
    d_s     = EW'(m1_r) * EW'(td_r) * EW'(BYTES_I) + EW'(m3_r) * EW'(tk_r) * EW'(BYTES_P);
    avail_s = {1'b0, EW'(GLB_BYTES)} + {1'b0, r_s};
    cost_s  = {1'b0, f_s} + {1'b0, b_s};
    nofit_s = (cost_s >= avail_s);
    num_s   = EW'(avail_s - cost_s);
    div_start_s = (state_r == ST_LOAD) && !nofit_s && (d_s != '0);
  end

  // Clamp and pointwise alignment of the divider result.
  always_comb begin
    q_s = (div_quo_s > TILE_N_MAX) ? TILE_N_MAX : div_quo_s;
    if (lt_r == LT_PW) begin
      aligned_s = q_s & ALIGN_MASK;
    end else begin
      aligned_s = q_s;
    end
    align_nofit_s = (aligned_s == '0) && (q_s != '0);
  end

  seq_udiv #(
    .W  (N_W),
    .XW (EXT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .dividend (num_s),
    .divisor  (d_s),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      tile_n_r   <= '0;
      err_r      <= 2'b00;
      lt_r       <= LT_PW;
      kh_r       <= 2'd0;
      kw_r       <= 2'd0;
      td_r       <= '0;
      tk_r       <= '0;
      tdf_r      <= '0;
      tkf_r      <= '0;
      m1_r       <= '0;
      m2_r       <= '0;
      m3_r       <= '0;
      early_r    <= 1'b0;
      res_r      <= '0;
      err_pend_r <= 2'b00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ready_r && bus.start) begin
            lt_r    <= layer_type_e'(bus.layer_type);
            kh_r    <= bus.kH;
            kw_r    <= bus.kW;
            td_r    <= bus.tile_D;
            tk_r    <= bus.tile_K;
            tdf_r   <= bus.tile_D_f;
            tkf_r   <= bus.tile_K_f;
            m1_r    <= bus.M1;
            m2_r    <= bus.M2;
            m3_r    <= bus.M3;
            ready_r <= 1'b0;
            state_r <= ST_LOAD;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (nofit_s) begin
            res_r      <= '0;
            err_pend_r <= ERR_NOFIT_M;
            early_r    <= 1'b1;
            state_r    <= ST_ALIGN;
          end else if (d_s == '0) begin
            res_r      <= TILE_N_MAX;
            err_pend_r <= ERR_DIV0_M;
            early_r    <= 1'b1;
            state_r    <= ST_ALIGN;
          end else begin
            early_r    <= 1'b0;
            state_r    <= ST_DIV;
          end
        end
        ST_DIV: begin
          // An idle divider here would be a fault; leaving DIV keeps the FSM from stalling.
          if (div_done_s || !div_busy_s) begin
            state_r <= ST_ALIGN;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_ALIGN: begin
          // Early-exit results are reported as decided in LOAD, without alignment.
          if (early_r) begin
            tile_n_r <= res_r;
            err_r    <= err_pend_r;
          end else begin
            tile_n_r <= aligned_s;
            err_r    <= align_nofit_s ? ERR_NOFIT_M : 2'b00;
          end
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.done   = done_r;
  assign bus.tile_n = tile_n_r;
  assign bus.err    = err_r;

endmodule
